gray_code_counter: RTL and testbench

Sequential binary-to-Gray encoder: a WIDTH-bit up/down counter that keeps its binary state and a registered Gray-coded copy in lockstep. Each new code is offered downstream through a valid/ready handshake. It is the producing end for the existing Gray-to-binary decode path: a downstream Gray-to-binary stage fed from `gray` recovers `bin` exactly. Typical use is generating Gray-coded position or pointer values for consumers that need single-bit transitions.

---
 rtl/gray_pkg.sv | 27 ++
 rtl/binary_to_gray.sv | 13 +
 rtl/gray_code_counter.sv | 75 +++++++
 tb/tb_gray_code_counter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code counter and its decode partner.
package gray_pkg;

  localparam int DEFAULT_WIDTH = 3;
  localparam int GRAY_MAX_W    = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } hs_state_t;

  // Binary to Gray; narrower values are passed zero-extended to GRAY_MAX_W.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary (prefix XOR from the MSB); zero-extension is transparent.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/binary_to_gray.sv
// Purely combinational WIDTH-bit binary to Gray encoder.
module binary_to_gray
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = WIDTH'(bin2gray(GRAY_MAX_W'(bin)));

endmodule

// File: rtl/gray_code_counter.sv
// Up/down binary counter with a registered Gray copy, offered downstream
// through a valid/ready handshake; wrap pulses on modulus crossings.
module gray_code_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  input  logic             out_ready,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             out_valid,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  hs_state_t        state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] gray_nxt;
  logic             wrap_nxt;
  logic             accept;
  logic             step;

  assign out_valid = (state == FULL);
  assign bin       = cnt;

  // Accept is the only combinational use of out_ready; a step needs room.
  assign accept = out_valid & out_ready;
  assign step   = en & ~load & (~out_valid | accept);

  // Encode the next count so gray is registered alongside cnt.
  binary_to_gray #(.WIDTH(WIDTH)) u_enc (
    .bin  (cnt_nxt),
    .gray (gray_nxt)
  );

  // Next count, wrap detection and handshake transition; load wins over all.
  always_comb begin
    cnt_nxt   = cnt;
    wrap_nxt  = 1'b0;
    state_nxt = state;
    if (load) begin
      cnt_nxt   = load_bin;
      state_nxt = FULL;
    end else if (step) begin
      cnt_nxt   = up ? cnt + ONE : cnt - ONE;
      wrap_nxt  = up ? (cnt == '1) : (cnt == '0);
      state_nxt = FULL;
    end else if (accept) begin
      state_nxt = EMPTY;
    end
  end

  // State register: count, code, handshake and wrap pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      cnt   <= '0;
      gray  <= '0;
      wrap  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      gray  <= gray_nxt;
      wrap  <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_gray_code_counter.sv
// Directed bench for gray_code_counter at WIDTH = 3.
module tb_gray_code_counter;
  import gray_pkg::*;

  localparam int W = 3;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] load_bin;
  logic         out_ready;
  logic [W-1:0] bin;
  logic [W-1:0] gray;
  logic         out_valid;
  logic         wrap;

  int total;
  int bad;

  gray_code_counter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .up        (up),
    .load      (load),
    .load_bin  (load_bin),
    .out_ready (out_ready),
    .bin       (bin),
    .gray      (gray),
    .out_valid (out_valid),
    .wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Encoding invariant and loopback decode, checked every cycle out of reset.
  always @(negedge clk) begin
    logic [W-1:0] dec;
    if (rst_n === 1'b1) begin
      dec = W'(gray2bin(GRAY_MAX_W'(gray)));
      chk("invariant", 32'(gray), 32'(bin ^ (bin >> 1)));
      chk("loopback", 32'(dec), 32'(bin));
    end
  end

  initial begin
    logic [W-1:0] up_gray [8];
    logic [W-1:0] prev;
    up_gray = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    total = 0;
    bad = 0;
    en = 0; up = 1; load = 0; load_bin = '0; out_ready = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    // reset clears immediately, before any clock edge
    chk("rst_bin", 32'(bin), 32'd0);
    chk("rst_gray", 32'(gray), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    cyc();
    rst_n = 1'b1;

    // up count with ready held high
    en = 1; up = 1; out_ready = 1;
    prev = 3'b000;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk($sformatf("up_gray%0d", i), 32'(gray), 32'(up_gray[i]));
      chk($sformatf("up_wrap%0d", i), 32'(wrap), (i == 7) ? 32'd1 : 32'd0);
      chk($sformatf("up_valid%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("up_onebit%0d", i), 32'($countones(gray ^ prev)), 32'd1);
      prev = gray;
    end

    // down from zero
    up = 0;
    cyc();
    chk("dn_bin0", 32'(bin), 32'h7);
    chk("dn_gray0", 32'(gray), 32'h4);
    chk("dn_wrap0", 32'(wrap), 32'd1);
    cyc();
    chk("dn_bin1", 32'(bin), 32'h6);
    chk("dn_gray1", 32'(gray), 32'h5);
    chk("dn_wrap1", 32'(wrap), 32'd0);

    // load 2 (gray 011), then backpressure
    load = 1; load_bin = 3'd2;
    cyc();
    chk("ld2_gray", 32'(gray), 32'h3);
    chk("ld2_valid", 32'(out_valid), 32'd1);
    load = 0; up = 1; out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("stall_gray%0d", i), 32'(gray), 32'h3);
      chk($sformatf("stall_valid%0d", i), 32'(out_valid), 32'd1);
    end
    out_ready = 1;
    cyc();
    chk("acc_step_gray", 32'(gray), 32'h2);
    chk("acc_step_bin", 32'(bin), 32'h3);

    // load during a stall
    out_ready = 0;
    load = 1; load_bin = 3'd5;
    cyc();
    chk("ldst_bin", 32'(bin), 32'h5);
    chk("ldst_gray", 32'(gray), 32'h7);
    chk("ldst_valid", 32'(out_valid), 32'd1);
    chk("ldst_wrap", 32'(wrap), 32'd0);
    load = 0;

    // accept without step empties and holds the code
    en = 0; out_ready = 1;
    cyc();
    chk("acc_only_valid", 32'(out_valid), 32'd0);
    chk("acc_only_bin", 32'(bin), 32'h5);
    chk("acc_only_gray", 32'(gray), 32'h7);

    // step from EMPTY with ready low
    en = 1; up = 1; out_ready = 0;
    cyc();
    chk("empty_step_bin", 32'(bin), 32'h6);
    chk("empty_step_gray", 32'(gray), 32'h5);
    chk("empty_step_valid", 32'(out_valid), 32'd1);

    // async reset mid-stream, between edges
    #2 rst_n = 1'b0;
    #1;
    chk("arst_bin", 32'(bin), 32'd0);
    chk("arst_gray", 32'(gray), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_wrap", 32'(wrap), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("post_rst_bin", 32'(bin), 32'h1);
    chk("post_rst_gray", 32'(gray), 32'h1);
    chk("post_rst_valid", 32'(out_valid), 32'd1);

    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
